// File: rtl/regfile_scoreboard.sv
// Integer register file (2 async reads, 1 sync write, x0 = 0) with a post-reset clear
// sequencer and a per-register busy scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
) (
   input  logic            clock,
   input  logic            reset,
   output logic            ready,
   input  logic            RegWrite,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] write_data,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            busy1,
   output logic            busy2,
   output logic            hazard
);

   localparam int unsigned NREGS = 1 << AW;
   localparam logic [AW:0] LastIdx = (AW + 1)'(NREGS - 1);

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e          state_q, state_d;
   logic [AW:0]     clr_idx_q, clr_idx_d;
   logic [NREGS-1:0] busy_q, busy_d;
   logic [XLEN-1:0] regs_q [NREGS];
   logic            run;
   logic            wr_en;
   logic            fwd1, fwd2;

   assign run   = (state_q == StReady) && !reset;
   assign wr_en = RegWrite && (rd != '0);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == StInit) begin
         clr_idx_d = clr_idx_q + 1'b1;
         if (clr_idx_q == LastIdx) begin
            state_d = StReady;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StInit;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Array has no reset; INIT zeroes it one entry per cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state_q == StInit) begin
            regs_q[clr_idx_q[AW-1:0]] <= '0;
         end else if (wr_en) begin
            regs_q[rd] <= write_data;
         end
      end
   end

   // A same-cycle issue to k overrides the writeback clear: the newer producer owns k.
   always_comb begin
      busy_d = '0;
      if (state_q == StReady) begin
         busy_d = busy_q;
         for (int unsigned k = 1; k < NREGS; k++) begin
            if (issue_valid && (issue_rd == AW'(k))) begin
               busy_d[k] = 1'b1;
            end else if (RegWrite && (rd == AW'(k))) begin
               busy_d[k] = 1'b0;
            end
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign fwd1 = run && wr_en && (rd == rs1);
   assign fwd2 = run && wr_en && (rd == rs2);
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   always_comb begin
      read_data1 = '0;
      read_data2 = '0;
      if (fwd1) begin
         read_data1 = write_data;
      end else if (rs1 != '0) begin
         read_data1 = regs_q[rs1];
      end
      if (fwd2) begin
         read_data2 = write_data;
      end else if (rs2 != '0) begin
         read_data2 = regs_q[rs2];
      end
   end

   assign ready  = run;
   assign busy1  = run && (rs1 != '0) && busy_q[rs1] && !fwd1;
   assign busy2  = run && (rs2 != '0) && busy_q[rs2] && !fwd2;
   assign hazard = busy1 || busy2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: literal checks plus a per-cycle compare against a
// behavioural model of registers, busy flags and the clear-sequence length.
module tb_regfile_scoreboard;

   localparam int NREGS = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ready;
   logic        RegWrite = 1'b0;
   logic [4:0]  rd = '0;
   logic [31:0] write_data = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [31:0] read_data1, read_data2;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        busy1, busy2, hazard;

   int checks = 0;
   int failures = 0;

   regfile_scoreboard #(.XLEN(32), .AW(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .ready       (ready),
      .RegWrite    (RegWrite),
      .rd          (rd),
      .write_data  (write_data),
      .rs1         (rs1),
      .rs2         (rs2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .busy1       (busy1),
      .busy2       (busy2),
      .hazard      (hazard)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: ready after NREGS non-reset edges; then plain array + busy-bit semantics.
   logic [31:0] m_regs [NREGS];
   bit          m_busy [NREGS];
   bit          m_ready = 1'b0;
   int          m_cnt = 0;

   initial begin
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      forever begin
         @(posedge clock);
         if (reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int i = 0; i < NREGS; i++) begin
               m_regs[i] = '0;
               m_busy[i] = 1'b0;
            end
         end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREGS) m_ready = 1'b1;
         end else begin
            if (RegWrite && rd != 0) begin
               m_regs[rd] = write_data;
               m_busy[rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
         end
      end
   end

   initial begin
      logic        e_rdy, f1, f2, e_b1, e_b2;
      logic [31:0] e_d1, e_d2;
      @(posedge clock);
      forever begin
         @(negedge clock);
         e_rdy = m_ready && !reset;
         f1    = BYP && e_rdy && RegWrite && rd != 0 && rd == rs1;
         f2    = BYP && e_rdy && RegWrite && rd != 0 && rd == rs2;
         e_d1  = f1 ? write_data : (rs1 == 0 ? 32'h0 : m_regs[rs1]);
         e_d2  = f2 ? write_data : (rs2 == 0 ? 32'h0 : m_regs[rs2]);
         e_b1  = e_rdy && rs1 != 0 && m_busy[rs1] && !f1;
         e_b2  = e_rdy && rs2 != 0 && m_busy[rs2] && !f2;
         check("cmp_ready", {31'b0, ready}, {31'b0, e_rdy});
         check("cmp_busy1", {31'b0, busy1}, {31'b0, e_b1});
         check("cmp_busy2", {31'b0, busy2}, {31'b0, e_b2});
         check("cmp_hazard", {31'b0, hazard}, {31'b0, e_b1 | e_b2});
         if (e_rdy) begin
            check("cmp_rd1", read_data1, e_d1);
            check("cmp_rd2", read_data2, e_d2);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      RegWrite    = 1'b0;
      issue_valid = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int first = -1;
      for (int i = 1; i <= 40 && first < 0; i++) begin
         tick();
         if (ready === 1'b1) first = i;
      end
      check(name, 32'(first), 32'd32);
   endtask

   initial begin
      // Clear sequence after a one-cycle reset pulse
      reset = 1'b1;
      rs1   = 5'd7;
      tick();
      reset = 1'b0;
      wait_ready("clear_len");
      check("clear_rd1", read_data1, 32'h0);

      // Write then read
      RegWrite = 1'b1; rd = 5'd5; write_data = 32'hDEADBEEF;
      tick();
      idle(); rs1 = 5'd5; rs2 = 5'd0; #1;
      check("wr_rd1", read_data1, 32'hDEADBEEF);
      check("wr_rd2", read_data2, 32'h0);

      // x0 protection
      RegWrite = 1'b1; rd = 5'd0; write_data = 32'hFFFFFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      idle(); rs1 = 5'd0; #1;
      check("x0_data", read_data1, 32'h0);
      check("x0_busy", {31'b0, busy1}, 32'h0);

      // Scoreboard set / clear / set-wins
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      idle(); rs1 = 5'd9; #1;
      check("sb_set_busy1", {31'b0, busy1}, 32'h1);
      check("sb_set_hazard", {31'b0, hazard}, 32'h1);
      RegWrite = 1'b1; rd = 5'd9; write_data = 32'h99;
      tick();
      idle(); #1;
      check("sb_clr_busy1", {31'b0, busy1}, 32'h0);
      check("sb_clr_rd1", read_data1, 32'h99);
      issue_valid = 1'b1; issue_rd = 5'd9;
      RegWrite = 1'b1; rd = 5'd9; write_data = 32'h77;
      tick();
      idle(); rs2 = 5'd9; #1;
      check("sb_win_busy1", {31'b0, busy1}, 32'h1);
      check("sb_win_busy2", {31'b0, busy2}, 32'h1);
      check("sb_win_rd1", read_data1, 32'h77);
      RegWrite = 1'b1; rd = 5'd9; write_data = 32'h0;
      tick();
      idle();

      // Bypass on rs2 while x3 is busy
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      idle(); rs1 = 5'd0; rs2 = 5'd3;
      RegWrite = 1'b1; rd = 5'd3; write_data = 32'h12345678; #1;
      check("byp_rd2", read_data2, BYP ? 32'h12345678 : 32'h0);
      check("byp_busy2", {31'b0, busy2}, BYP ? 32'h0 : 32'h1);
      tick();
      idle(); #1;
      check("byp_after_rd2", read_data2, 32'h12345678);
      check("byp_after_busy2", {31'b0, busy2}, 32'h0);

      // Reset mid-INIT, with writes/issues that INIT must ignore
      issue_valid = 1'b1; issue_rd = 5'd12;
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      RegWrite = 1'b1; rd = 5'd4; write_data = 32'hAAAA;
      issue_valid = 1'b1; issue_rd = 5'd4;
      for (int i = 1; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_ready("reinit_len");
      idle(); rs1 = 5'd4; rs2 = 5'd12; #1;
      check("reinit_rd1", read_data1, 32'h0);
      check("reinit_busy1", {31'b0, busy1}, 32'h0);
      check("reinit_busy2", {31'b0, busy2}, 32'h0);
      check("reinit_hazard", {31'b0, hazard}, 32'h0);
      rs1 = 5'd5; #1;
      check("reinit_x5", read_data1, 32'h0);

      // A few more writes for the per-cycle compare
      for (int i = 1; i < 8; i++) begin
         RegWrite = 1'b1; rd = 5'(i * 3); write_data = 32'h1000 + 32'(i);
         issue_valid = 1'b1; issue_rd = 5'(i * 5);
         rs1 = 5'(i * 3); rs2 = 5'(i * 5);
         tick();
      end
      idle();
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
